// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store.
// Optional ARB_PERF_CNT_EN adds saturating per-port stall-cycle counters.
module mem_port_arbiter #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned MAX_D  = 4,
    parameter int unsigned TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_rdata,
    output logic          err,
    output logic [31:0]   i_wait_cnt,
    output logic [31:0]   d_wait_cnt
);

    localparam int unsigned DCW = 4;
    localparam int unsigned TCW = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    state_t          r_state,     w_state_nxt;
    logic [DCW-1:0]  r_dcnt,      w_dcnt_nxt;
    logic [TCW-1:0]  r_tcnt,      w_tcnt_nxt;
    logic            r_i_ack,     w_i_ack_nxt;
    logic            r_d_ack,     w_d_ack_nxt;
    logic [DW-1:0]   r_i_rdata,   w_i_rdata_nxt;
    logic [DW-1:0]   r_d_rdata,   w_d_rdata_nxt;
    logic            r_mem_req,   w_mem_req_nxt;
    logic            r_mem_we,    w_mem_we_nxt;
    logic [AW-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic            r_err,       w_err_nxt;
    logic            w_tout;
    logic            w_fetch_forced;
    logic [DW-1:0]   w_rd_val;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dcnt      <= '0;
            r_tcnt      <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_i_ack     <= w_i_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Grant selection, completion/timeout handling
    always_comb begin
        w_state_nxt     = r_state;
        w_dcnt_nxt      = r_dcnt;
        w_tcnt_nxt      = r_tcnt;
        w_i_ack_nxt     = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_err_nxt       = r_err;
        w_tout          = (r_tcnt == TCW'(TO_CYC - 1));
        w_fetch_forced  = i_req && (r_dcnt == DCW'(MAX_D));
        w_rd_val        = mem_rdy ? mem_rdata : '0;

        case (r_state)
            S_IDLE: begin
                if (d_req && !w_fetch_forced) begin
                    w_state_nxt     = S_BUSY_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_tcnt_nxt      = '0;
                    w_dcnt_nxt      = i_req ? r_dcnt + DCW'(1) : '0;
                end else if (i_req) begin
                    w_state_nxt     = S_BUSY_I;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = i_addr;
                    w_mem_wdata_nxt = '0;
                    w_tcnt_nxt      = '0;
                    w_dcnt_nxt      = '0;
                end else begin
                    w_dcnt_nxt = '0;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                // A timeout completes like a normal access but returns zero data
                if (mem_rdy || w_tout) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    if (!mem_rdy) begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_state == S_BUSY_I) begin
                        w_i_ack_nxt   = 1'b1;
                        w_i_rdata_nxt = w_rd_val;
                    end else begin
                        w_d_ack_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_nxt = w_rd_val;
                        end
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + TCW'(1);
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;
    assign i_stall   = i_req & ~r_i_ack;
    assign d_stall   = d_req & ~r_d_ack;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_i_wait_cnt;
    logic [31:0] r_d_wait_cnt;

    // Saturating stall-cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_wait_cnt <= '0;
            r_d_wait_cnt <= '0;
        end else begin
            if (i_stall && (r_i_wait_cnt != 32'hFFFF_FFFF)) begin
                r_i_wait_cnt <= r_i_wait_cnt + 32'd1;
            end
            if (d_stall && (r_d_wait_cnt != 32'hFFFF_FFFF)) begin
                r_d_wait_cnt <= r_d_wait_cnt + 32'd1;
            end
        end
    end

    assign i_wait_cnt = r_i_wait_cnt;
    assign d_wait_cnt = r_d_wait_cnt;
`else
    assign i_wait_cnt = 32'h0;
    assign d_wait_cnt = 32'h0;
`endif

endmodule
